// File: rtl/cfg_frame_assembler_pkg.sv
// Shared constants for the configuration write stream: sync word, desync flag
// position and the frame assembler state encoding.
package cfg_frame_assembler_pkg;

    localparam logic [31:0] SYNC_WORD           = 32'hFAB0_FAB1;
    localparam int          DESYNC_FLAG_DEFAULT = 20;

    typedef enum logic [1:0] {
        ST_UNSYNCED = 2'd0,
        ST_ADDR     = 2'd1,
        ST_DATA     = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/cfg_frame_assembler.sv
// Sink of the 32-bit configuration write stream: locks onto the sync word, then
// splits the stream into frame-address words and per-row frame data writes.
module cfg_frame_assembler
    import cfg_frame_assembler_pkg::*;
#(
    parameter int NUMBER_OF_ROWS     = 4,
    parameter int FRAME_BITS_PER_ROW = 32,
    parameter int ROW_SELECT_WIDTH   = 5,
    parameter int DESYNC_FLAG        = DESYNC_FLAG_DEFAULT
) (
    input  logic                          clk_system_i,
    input  logic                          reset_n_i,
    input  logic [31:0]                   write_data_i,
    input  logic                          write_strobe_i,
    output logic [31:0]                   frame_address_o,
    output logic [ROW_SELECT_WIDTH-1:0]   row_select_o,
    output logic [FRAME_BITS_PER_ROW-1:0] row_data_o,
    output logic                          row_strobe_o,
    output logic                          long_frame_strobe_o,
    output logic                          synced_o,
    output logic [15:0]                   frame_count_o
);

    localparam logic [ROW_SELECT_WIDTH-1:0] LAST_ROW = ROW_SELECT_WIDTH'(NUMBER_OF_ROWS - 1);

    cfg_state_e                    state_r;
    cfg_state_e                    state_next_s;
    logic [ROW_SELECT_WIDTH-1:0]   row_cnt_r;
    logic [ROW_SELECT_WIDTH-1:0]   row_cnt_next_s;
    logic [31:0]                   frame_addr_r;
    logic [31:0]                   frame_addr_next_s;
    logic [ROW_SELECT_WIDTH-1:0]   row_select_r;
    logic [FRAME_BITS_PER_ROW-1:0] row_data_r;
    logic                          row_strobe_r;
    logic                          last_row_r;
    logic                          long_frame_r;
    logic                          synced_r;
    logic [15:0]                   frame_count_r;
    logic                          row_load_s;
    logic                          last_row_s;

    // Next-state decode; sync/desync words are only recognised outside DATA.
    always_comb begin
        state_next_s      = state_r;
        row_cnt_next_s    = row_cnt_r;
        frame_addr_next_s = frame_addr_r;
        row_load_s        = 1'b0;
        last_row_s        = 1'b0;
        case (state_r)
            ST_UNSYNCED: begin
                if (write_strobe_i && (write_data_i == SYNC_WORD)) begin
                    state_next_s = ST_ADDR;
                end else begin
                    state_next_s = ST_UNSYNCED;
                end
            end
            ST_ADDR: begin
                if (!write_strobe_i) begin
                    state_next_s = ST_ADDR;
                end else if (write_data_i == SYNC_WORD) begin
                    state_next_s = ST_ADDR;
                end else if (write_data_i[DESYNC_FLAG]) begin
                    state_next_s = ST_UNSYNCED;
                end else begin
                    frame_addr_next_s = write_data_i;
                    row_cnt_next_s    = {ROW_SELECT_WIDTH{1'b0}};
                    state_next_s      = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!write_strobe_i) begin
                    state_next_s = ST_DATA;
                end else if (row_cnt_r == LAST_ROW) begin
                    row_load_s     = 1'b1;
                    last_row_s     = 1'b1;
                    row_cnt_next_s = {ROW_SELECT_WIDTH{1'b0}};
                    state_next_s   = ST_ADDR;
                end else begin
                    row_load_s     = 1'b1;
                    row_cnt_next_s = row_cnt_r + ROW_SELECT_WIDTH'(1);
                    state_next_s   = ST_DATA;
                end
            end
            default: begin
                state_next_s   = ST_UNSYNCED;
                row_cnt_next_s = {ROW_SELECT_WIDTH{1'b0}};
            end
        endcase
    end

    // State, row counter and registered outputs; the long-frame pulse trails
    // the final row write by one cycle so it follows the last row_strobe_o.
    always_ff @(posedge clk_system_i) begin
        if (!reset_n_i) begin
            state_r       <= ST_UNSYNCED;
            row_cnt_r     <= {ROW_SELECT_WIDTH{1'b0}};
            frame_addr_r  <= 32'h0000_0000;
            row_select_r  <= {ROW_SELECT_WIDTH{1'b0}};
            row_data_r    <= {FRAME_BITS_PER_ROW{1'b0}};
            row_strobe_r  <= 1'b0;
            last_row_r    <= 1'b0;
            long_frame_r  <= 1'b0;
            synced_r      <= 1'b0;
            frame_count_r <= 16'h0000;
        end else begin
            state_r      <= state_next_s;
            row_cnt_r    <= row_cnt_next_s;
            frame_addr_r <= frame_addr_next_s;
            row_strobe_r <= row_load_s;
            last_row_r   <= last_row_s;
            long_frame_r <= last_row_r;
            synced_r     <= (state_next_s != ST_UNSYNCED);
            if (row_load_s) begin
                row_data_r   <= write_data_i;
                row_select_r <= row_cnt_r;
            end else begin
                row_data_r   <= row_data_r;
                row_select_r <= row_select_r;
            end
            if (last_row_r && (frame_count_r != 16'hFFFF)) begin
                frame_count_r <= frame_count_r + 16'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign frame_address_o     = frame_addr_r;
    assign row_select_o        = row_select_r;
    assign row_data_o          = row_data_r;
    assign row_strobe_o        = row_strobe_r;
    assign long_frame_strobe_o = long_frame_r;
    assign synced_o            = synced_r;
    assign frame_count_o       = frame_count_r;

endmodule

// File: tb/tb_cfg_frame_assembler.sv
// Directed bench for cfg_frame_assembler: inputs change and outputs are
// sampled on the falling clock edge, one word per call of drive().
module tb_cfg_frame_assembler;

    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic        clk;
    logic        reset_n;
    logic [31:0] write_data;
    logic        write_strobe;
    logic [31:0] frame_address;
    logic [4:0]  row_select;
    logic [31:0] row_data;
    logic        row_strobe;
    logic        long_frame_strobe;
    logic        synced;
    logic [15:0] frame_count;

    int checks;
    int errors;

    cfg_frame_assembler dut (
        .clk_system_i        (clk),
        .reset_n_i           (reset_n),
        .write_data_i        (write_data),
        .write_strobe_i      (write_strobe),
        .frame_address_o     (frame_address),
        .row_select_o        (row_select),
        .row_data_o          (row_data),
        .row_strobe_o        (row_strobe),
        .long_frame_strobe_o (long_frame_strobe),
        .synced_o            (synced),
        .frame_count_o       (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic s, input logic [31:0] w);
        write_strobe = s;
        write_data   = w;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [4:0] sel, input logic [31:0] dat);
        chk({tag, " strobe"}, 32'(row_strobe), 32'd1);
        chk({tag, " select"}, 32'(row_select), 32'(sel));
        chk({tag, " data"}, row_data, dat);
        chk({tag, " long"}, 32'(long_frame_strobe), 32'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        write_strobe = 1'b0;
        write_data   = 32'h0;
        @(negedge clk);
        drive(1'b0, 32'h0);
        drive(1'b0, 32'h0);
        reset_n = 1'b1;

        // Reset state
        chk("rst synced", 32'(synced), 32'd0);
        chk("rst addr", frame_address, 32'h0);
        chk("rst count", 32'(frame_count), 32'd0);
        chk("rst row_strobe", 32'(row_strobe), 32'd0);
        chk("rst long", 32'(long_frame_strobe), 32'd0);

        // Sync only
        drive(1'b1, SYNC);
        chk("sync synced", 32'(synced), 32'd1);
        chk("sync row_strobe", 32'(row_strobe), 32'd0);

        // Full frame
        drive(1'b1, 32'h0001_0003);
        chk("ff addr", frame_address, 32'h0001_0003);
        chk("ff row_strobe idle", 32'(row_strobe), 32'd0);
        drive(1'b1, 32'hA0);
        chk_row("ff row0", 5'd0, 32'hA0);
        drive(1'b1, 32'hA1);
        chk_row("ff row1", 5'd1, 32'hA1);
        drive(1'b1, 32'hA2);
        chk_row("ff row2", 5'd2, 32'hA2);
        drive(1'b1, 32'hA3);
        chk_row("ff row3", 5'd3, 32'hA3);
        drive(1'b0, 32'h0);
        chk("ff long", 32'(long_frame_strobe), 32'd1);
        chk("ff row_strobe off", 32'(row_strobe), 32'd0);
        chk("ff count", 32'(frame_count), 32'd1);
        chk("ff hold data", row_data, 32'hA3);
        chk("ff hold select", 32'(row_select), 32'd3);
        drive(1'b0, 32'h0);
        chk("ff long single", 32'(long_frame_strobe), 32'd0);
        chk("ff synced", 32'(synced), 32'd1);

        // Desync, then an address-like word is ignored
        drive(1'b1, 32'h0010_0000);
        chk("desync synced", 32'(synced), 32'd0);
        chk("desync addr", frame_address, 32'h0001_0003);
        drive(1'b1, 32'h0000_0005);
        chk("ignored addr", frame_address, 32'h0001_0003);
        chk("ignored synced", 32'(synced), 32'd0);

        // Non-sync word while unsynced; repeated sync; sync never desyncs
        drive(1'b1, 32'h1234_5678);
        chk("junk synced", 32'(synced), 32'd0);
        drive(1'b1, SYNC);
        chk("sync1 synced", 32'(synced), 32'd1);
        drive(1'b1, SYNC);
        chk("sync2 synced", 32'(synced), 32'd1);
        chk("sync2 addr", frame_address, 32'h0001_0003);
        drive(1'b1, 32'h0000_0002);
        chk("addr2", frame_address, 32'h0000_0002);
        chk("addr2 synced", 32'(synced), 32'd1);

        // Sync word in the data phase is plain data
        drive(1'b1, 32'h11);
        chk_row("imm row0", 5'd0, 32'h11);
        drive(1'b1, SYNC);
        chk_row("imm row1", 5'd1, SYNC);
        drive(1'b1, 32'h0010_0033);
        chk_row("imm row2", 5'd2, 32'h0010_0033);
        drive(1'b1, 32'h44);
        chk_row("imm row3", 5'd3, 32'h44);
        drive(1'b0, 32'h0);
        chk("imm long", 32'(long_frame_strobe), 32'd1);
        chk("imm count", 32'(frame_count), 32'd2);
        chk("imm synced", 32'(synced), 32'd1);

        // Reset mid-frame
        drive(1'b1, SYNC);
        drive(1'b1, 32'h0000_0007);
        chk("mid addr", frame_address, 32'h0000_0007);
        drive(1'b1, 32'hD0);
        drive(1'b1, 32'hD1);
        chk_row("mid row1", 5'd1, 32'hD1);
        reset_n = 1'b0;
        drive(1'b0, 32'h0);
        reset_n = 1'b1;
        chk("mid rst addr", frame_address, 32'h0);
        chk("mid rst data", row_data, 32'h0);
        chk("mid rst select", 32'(row_select), 32'd0);
        chk("mid rst strobe", 32'(row_strobe), 32'd0);
        chk("mid rst long", 32'(long_frame_strobe), 32'd0);
        chk("mid rst synced", 32'(synced), 32'd0);
        chk("mid rst count", 32'(frame_count), 32'd0);
        drive(1'b1, 32'hE0);
        chk("post rst strobe0", 32'(row_strobe), 32'd0);
        drive(1'b1, 32'hE1);
        chk("post rst strobe1", 32'(row_strobe), 32'd0);
        drive(1'b1, 32'hE2);
        chk("post rst strobe2", 32'(row_strobe), 32'd0);
        drive(1'b1, 32'hE3);
        chk("post rst strobe3", 32'(row_strobe), 32'd0);
        drive(1'b0, 32'h0);
        chk("post rst long", 32'(long_frame_strobe), 32'd0);
        chk("post rst synced", 32'(synced), 32'd0);
        chk("post rst data", row_data, 32'h0);
        chk("post rst count", 32'(frame_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
